hack_rom_loader: RTL

Writer side of the instruction-ROM interface. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit Hack instructions, and writes them to consecutive instruction-memory addresses starting at 0. The CPU is held in reset for the whole load and released only after the last word is written. The block sits between a host byte source (UART receiver, debug bridge) and the write port of the instruction memory.

---
 rtl/hack_rom_loader_if.sv | 28 ++
 rtl/hack_rom_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hack_rom_loader_if.sv
// Byte-stream, instruction-ROM write and status bundle for the Hack ROM loader.
// master: host/byte source side; slave: the loader itself.
interface hack_rom_loader_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, rom_we, rom_addr, rom_data, cpu_reset, busy, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, rom_we, rom_addr, rom_data, cpu_reset, busy, done, error
  );
endinterface

// File: rtl/hack_rom_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory from address 0,
// holding the CPU in reset until the whole image has been written.
module hack_rom_loader #(
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned DATA_W        = 16,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input logic              clk_i,
  input logic              rst_ni,
  hack_rom_loader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDatHi, StDatLo, StWrite, StDone, StError
  } state_e;

  localparam logic [ADDR_W:0]   RemOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              cpu_reset_q;
  logic              byte_ready;
  logic              xfer;
  logic [15:0]       len_n;
  logic [16:0]       len_ext;
  logic [16:0]       len_max;

  assign xfer    = bus.byte_valid & byte_ready;
  assign len_n   = {len_hi_q, bus.byte_in};
  assign len_ext = {1'b0, len_n};
  // One past the last address: N equal to this fills the memory exactly.
  assign len_max = 17'(1) << ADDR_W;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (bus.start) state_d = StLenHi;
      StLenHi: if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (xfer) begin
          if (len_n == 16'd0)          state_d = StDone;
          else if (len_ext > len_max)  state_d = StError;
          else                         state_d = StDatHi;
        end
      end
      StDatHi: if (xfer) state_d = StDatLo;
      StDatLo: if (xfer) state_d = StWrite;
      StWrite: state_d = (remaining_q == RemOne) ? StDone : StDatHi;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    bus.rom_we = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.error  = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StDatHi, StDatLo: begin
        byte_ready = 1'b1;
        bus.busy   = 1'b1;
      end
      StWrite: begin
        bus.rom_we = 1'b1;
        bus.busy   = 1'b1;
      end
      StDone:  bus.done  = 1'b1;
      StError: bus.error = 1'b1;
      default: ;
    endcase
  end

  assign bus.byte_ready = byte_ready;
  assign bus.rom_addr   = addr_q;
  assign bus.rom_data   = data_q;
  assign bus.cpu_reset  = cpu_reset_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_hi_q    <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cpu_reset_q <= HOLD_ON_RESET;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (bus.start) begin
            addr_q      <= '0;
            cpu_reset_q <= 1'b1;
          end
        end
        StLenHi: if (xfer) len_hi_q <= bus.byte_in;
        StLenLo: begin
          if (xfer) begin
            remaining_q <= (ADDR_W+1)'(len_n);
            if (len_n == 16'd0) cpu_reset_q <= 1'b0;
          end
        end
        StDatHi: if (xfer) data_q[DATA_W-1:8] <= bus.byte_in;
        StDatLo: if (xfer) data_q[7:0] <= bus.byte_in;
        StWrite: begin
          // The last increment may wrap to 0; harmless since the session ends here.
          addr_q      <= addr_q + AddrOne;
          remaining_q <= remaining_q - RemOne;
          if (remaining_q == RemOne) cpu_reset_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
